// File: rtl/pipe_scoreboard.sv
// ID-stage hazard/forwarding scoreboard: tracks in-flight writes over DEPTH stages
// and emits per-operand forward selects or an ID stall. Define PIPE_FWD_EN to enable forwarding.
module pipe_scoreboard #(
  parameter int NUM_SRC  = 2,
  parameter int DEPTH    = 3,
  parameter int REG_AW   = 5,
  parameter int ALU_RDY  = 2,
  parameter int LOAD_RDY = 3,
  localparam int SELW    = $clog2(DEPTH + 1)
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic [REG_AW-1:0]         id_dst_addr,
  input  logic                      id_dst_wr,
  input  logic                      id_is_load,
  input  logic                      flush,
  output logic                      stall,
  output logic [NUM_SRC*SELW-1:0]   fwd_sel,
  output logic [31:0]               stall_cnt
);

  localparam int RDY_MAX = (LOAD_RDY > ALU_RDY) ? LOAD_RDY : ALU_RDY;
  localparam int RDYW    = $clog2(RDY_MAX + 1);

  logic              vld_reg [1:DEPTH];
  logic [REG_AW-1:0] dst_reg [1:DEPTH];
`ifdef PIPE_FWD_EN
  logic [RDYW-1:0]   rdy_reg [1:DEPTH];
`else
  logic              unused_load;
  assign unused_load = id_is_load;
`endif

  logic [NUM_SRC-1:0] src_stall;
  logic               accept;
  logic [31:0]        stall_cnt_reg;
  logic [31:0]        stall_cnt_next;

  // Flush squashes the ID instruction, so it must never also hold the front end.
  assign stall  = (|src_stall) & ~flush;
  assign accept = id_valid & ~stall & ~flush;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [REG_AW-1:0] src;
      logic              chk;
      logic              hit;
      logic              hit_ready;
      logic [SELW-1:0]   hit_k;

      assign src = id_src_addr[gi*REG_AW +: REG_AW];
      assign chk = id_valid & id_src_used[gi] & (src != '0);

      // Scan oldest to youngest so the youngest matching stage is the last writer.
      always_comb begin
        hit       = 1'b0;
        hit_ready = 1'b0;
        hit_k     = '0;
        for (int k = DEPTH; k >= 1; k--) begin
          if (vld_reg[k] && (dst_reg[k] == src)) begin
            hit   = 1'b1;
            hit_k = SELW'(k);
`ifdef PIPE_FWD_EN
            hit_ready = (k >= int'(rdy_reg[k]));
`else
            hit_ready = (k == DEPTH);
`endif
          end
        end
      end

      assign src_stall[gi] = chk & hit & ~hit_ready;
`ifdef PIPE_FWD_EN
      assign fwd_sel[gi*SELW +: SELW] = (chk & hit & hit_ready) ? hit_k : '0;
`else
      // The last stage writes the regfile before ID reads it, so no select is needed.
      assign fwd_sel[gi*SELW +: SELW] = '0;
`endif
    end

    for (gi = 2; gi <= DEPTH; gi++) begin : g_shift
      always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
          vld_reg[gi] <= 1'b0;
          dst_reg[gi] <= '0;
`ifdef PIPE_FWD_EN
          rdy_reg[gi] <= '0;
`endif
        end else begin
          vld_reg[gi] <= vld_reg[gi-1];
          dst_reg[gi] <= dst_reg[gi-1];
`ifdef PIPE_FWD_EN
          rdy_reg[gi] <= rdy_reg[gi-1];
`endif
        end
      end
    end
  endgenerate

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      vld_reg[1] <= 1'b0;
      dst_reg[1] <= '0;
`ifdef PIPE_FWD_EN
      rdy_reg[1] <= '0;
`endif
    end else begin
      vld_reg[1] <= accept & id_dst_wr & (id_dst_addr != '0);
      dst_reg[1] <= id_dst_addr;
`ifdef PIPE_FWD_EN
      rdy_reg[1] <= id_is_load ? RDYW'(LOAD_RDY) : RDYW'(ALU_RDY);
`endif
    end
  end

  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    if (stall && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
      stall_cnt_next = stall_cnt_reg + 32'd1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      stall_cnt_reg <= '0;
    end else begin
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Directed bench for pipe_scoreboard: a per-cycle vector table plus hand-written
// reset, load-use and reset-mid-stall sequences. Expectations follow PIPE_FWD_EN.
module tb_pipe_scoreboard;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        id_valid = 1'b0;
  logic [9:0]  id_src_addr = '0;
  logic [1:0]  id_src_used = '0;
  logic [4:0]  id_dst_addr = '0;
  logic        id_dst_wr = 1'b0;
  logic        id_is_load = 1'b0;
  logic        flush = 1'b0;
  logic        stall;
  logic [3:0]  fwd_sel;
  logic [31:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clk = ~Clk;

  pipe_scoreboard dut (
    .Clk(Clk), .Reset(Reset), .id_valid(id_valid), .id_src_addr(id_src_addr),
    .id_src_used(id_src_used), .id_dst_addr(id_dst_addr), .id_dst_wr(id_dst_wr),
    .id_is_load(id_is_load), .flush(flush), .stall(stall), .fwd_sel(fwd_sel),
    .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic        v;
    logic [4:0]  s0, s1;
    logic [1:0]  used;
    logic [4:0]  dst;
    logic        wr, ld, fl;
    logic        e_stall;
    logic [1:0]  e_f0, e_f1;
    logic [31:0] e_cnt;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                              input logic [1:0] used, input logic [4:0] dst, input logic wr,
                              input logic ld, input logic fl, input logic e_stall,
                              input logic [1:0] e_f0, input logic [1:0] e_f1,
                              input logic [31:0] e_cnt);
    vec_t t;
    t.v = v; t.s0 = s0; t.s1 = s1; t.used = used; t.dst = dst; t.wr = wr; t.ld = ld;
    t.fl = fl; t.e_stall = e_stall; t.e_f0 = e_f0; t.e_f1 = e_f1; t.e_cnt = e_cnt;
    return t;
  endfunction

  task automatic drive(input vec_t t);
    id_valid    = t.v;
    id_src_addr = {t.s1, t.s0};
    id_src_used = t.used;
    id_dst_addr = t.dst;
    id_dst_wr   = t.wr;
    id_is_load  = t.ld;
    flush       = t.fl;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic e_stall, input logic [3:0] e_fwd,
                            input logic [31:0] e_cnt);
    check({tag, " stall"}, {31'd0, stall}, {31'd0, e_stall});
    check({tag, " fwd_sel"}, {28'd0, fwd_sel}, {28'd0, e_fwd});
    check({tag, " stall_cnt"}, stall_cnt, e_cnt);
    $display("%s: stall=%b fwd_sel=%h stall_cnt=%0d", tag, stall, fwd_sel, stall_cnt);
  endtask

  vec_t nop, t;
  logic [31:0] exp_cnt;

  initial begin
    nop = mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    //            v  s0  s1 used dst wr ld fl  st f0 f1 cnt
`ifdef PIPE_FWD_EN
    vecs[0]  = mk(1,  1,  2, 2'b11,  8, 1, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1,  8,  8, 2'b11,  9, 1, 0, 0, 1, 0, 0, 0);
    vecs[2]  = mk(1,  8,  8, 2'b11,  9, 1, 0, 0, 0, 2, 2, 1);
    vecs[3]  = mk(1,  8,  8, 2'b11,  9, 1, 0, 0, 0, 3, 3, 1);
    vecs[4]  = mk(0,  8,  8, 2'b11,  0, 0, 0, 0, 0, 0, 0, 1);
    vecs[5]  = mk(1,  9,  9, 2'b00,  0, 1, 0, 0, 0, 0, 0, 1);
    vecs[6]  = mk(1,  0,  0, 2'b11,  8, 0, 0, 0, 0, 0, 0, 1);
    vecs[7]  = mk(1,  1,  2, 2'b11, 10, 1, 1, 0, 0, 0, 0, 1);
    vecs[8]  = mk(1,  3, 10, 2'b11,  0, 0, 0, 0, 1, 0, 0, 1);
    vecs[9]  = mk(1,  3, 10, 2'b11,  0, 0, 0, 1, 0, 0, 0, 2);
    vecs[10] = mk(1,  3, 10, 2'b11,  0, 0, 0, 0, 0, 0, 3, 2);
    vecs[11] = mk(1,  1,  2, 2'b11, 11, 1, 0, 0, 0, 0, 0, 2);
    vecs[12] = mk(1,  1,  2, 2'b11, 11, 1, 1, 0, 0, 0, 0, 2);
    vecs[13] = mk(0,  0,  0, 2'b00,  0, 0, 0, 0, 0, 0, 0, 2);
    vecs[14] = mk(1, 11,  0, 2'b11,  0, 0, 0, 0, 1, 0, 0, 2);
    vecs[15] = mk(1, 11,  0, 2'b11,  0, 0, 0, 0, 0, 3, 0, 3);
    vecs[16] = mk(1,  1,  2, 2'b11, 12, 1, 0, 0, 0, 0, 0, 3);
    vecs[17] = mk(1,  1,  2, 2'b11, 13, 1, 0, 0, 0, 0, 0, 3);
    vecs[18] = mk(0,  0,  0, 2'b00,  0, 0, 0, 0, 0, 0, 0, 3);
    vecs[19] = mk(1, 13, 12, 2'b11,  0, 0, 0, 0, 0, 2, 3, 3);
    vecs[20] = mk(1, 13, 12, 2'b11,  0, 0, 0, 0, 0, 3, 0, 3);
    vecs[21] = mk(0,  0,  0, 2'b00,  0, 0, 0, 0, 0, 0, 0, 3);
`else
    vecs[0]  = mk(1,  1,  2, 2'b11,  8, 1, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1,  8,  8, 2'b11,  9, 1, 0, 0, 1, 0, 0, 0);
    vecs[2]  = mk(1,  8,  8, 2'b11,  9, 1, 0, 0, 1, 0, 0, 1);
    vecs[3]  = mk(1,  8,  8, 2'b11,  9, 1, 0, 0, 0, 0, 0, 2);
    vecs[4]  = mk(0,  8,  8, 2'b11,  0, 0, 0, 0, 0, 0, 0, 2);
    vecs[5]  = mk(1,  9,  9, 2'b00,  0, 1, 0, 0, 0, 0, 0, 2);
    vecs[6]  = mk(1,  0,  0, 2'b11,  8, 0, 0, 0, 0, 0, 0, 2);
    vecs[7]  = mk(1,  1,  2, 2'b11, 10, 1, 1, 0, 0, 0, 0, 2);
    vecs[8]  = mk(1,  3, 10, 2'b11,  0, 0, 0, 0, 1, 0, 0, 2);
    vecs[9]  = mk(1,  3, 10, 2'b11,  0, 0, 0, 1, 0, 0, 0, 3);
    vecs[10] = mk(1,  3, 10, 2'b11,  0, 0, 0, 0, 0, 0, 0, 3);
    vecs[11] = mk(1,  1,  2, 2'b11, 11, 1, 0, 0, 0, 0, 0, 3);
    vecs[12] = mk(1,  1,  2, 2'b11, 11, 1, 1, 0, 0, 0, 0, 3);
    vecs[13] = mk(0,  0,  0, 2'b00,  0, 0, 0, 0, 0, 0, 0, 3);
    vecs[14] = mk(1, 11,  0, 2'b11,  0, 0, 0, 0, 1, 0, 0, 3);
    vecs[15] = mk(1, 11,  0, 2'b11,  0, 0, 0, 0, 0, 0, 0, 4);
    vecs[16] = mk(1,  1,  2, 2'b11, 12, 1, 0, 0, 0, 0, 0, 4);
    vecs[17] = mk(1,  1,  2, 2'b11, 13, 1, 0, 0, 0, 0, 0, 4);
    vecs[18] = mk(0,  0,  0, 2'b00,  0, 0, 0, 0, 0, 0, 0, 4);
    vecs[19] = mk(1, 13, 12, 2'b11,  0, 0, 0, 0, 1, 0, 0, 4);
    vecs[20] = mk(1, 13, 12, 2'b11,  0, 0, 0, 0, 0, 0, 0, 5);
    vecs[21] = mk(0,  0,  0, 2'b00,  0, 0, 0, 0, 0, 0, 0, 5);
`endif

    // Held in reset with random ID traffic: everything stays quiet.
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      id_valid    = 1'($urandom);
      id_src_addr = 10'($urandom);
      id_src_used = 2'($urandom);
      id_dst_addr = 5'($urandom);
      id_dst_wr   = 1'($urandom);
      id_is_load  = 1'($urandom);
      flush       = 1'($urandom);
      #1 check_outs($sformatf("rst%0d", i), 1'b0, 4'h0, 32'd0);
    end
    @(negedge Clk);
    Reset = 1'b1;
    drive(nop);
    for (int i = 0; i < 3; i++) begin
      #1 check_outs($sformatf("nop%0d", i), 1'b0, 4'h0, 32'd0);
      @(negedge Clk);
    end

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      #1 check_outs($sformatf("vec%0d", i), vecs[i].e_stall,
                    {vecs[i].e_f1, vecs[i].e_f0}, vecs[i].e_cnt);
      @(negedge Clk);
    end

    // Load-use without flush: two stall cycles, then stage 3 (or regfile without forwarding).
    exp_cnt = vecs[NV-1].e_cnt;
    t = mk(1, 1, 2, 2'b11, 8, 1, 1, 0, 0, 0, 0, 0);
    drive(t);
    #1 check_outs("lu_load", 1'b0, 4'h0, exp_cnt);
    t = mk(1, 8, 0, 2'b11, 9, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      drive(t);
      #1 check_outs($sformatf("lu_stall%0d", i), 1'b1, 4'h0, exp_cnt + 32'(i));
    end
    @(negedge Clk);
`ifdef PIPE_FWD_EN
    #1 check_outs("lu_fwd", 1'b0, 4'h3, exp_cnt + 32'd2);
`else
    #1 check_outs("lu_fwd", 1'b0, 4'h0, exp_cnt + 32'd2);
`endif
    @(negedge Clk);
    drive(nop);
    #1 check_outs("lu_cnt", 1'b0, 4'h0, exp_cnt + 32'd2);

    // Reset asserted in the middle of a stall cycle drops stall at once.
    @(negedge Clk);
    drive(mk(1, 1, 2, 2'b11, 8, 1, 0, 0, 0, 0, 0, 0));
    @(negedge Clk);
    drive(mk(1, 8, 8, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0));
    #1 check_outs("mid_pre", 1'b1, 4'h0, exp_cnt + 32'd2);
    #1 Reset = 1'b0;
    #1 check_outs("mid_rst", 1'b0, 4'h0, 32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    #1 check_outs("mid_rel", 1'b0, 4'h0, 32'd0);
    @(negedge Clk);
    drive(nop);
    #1 check_outs("mid_nop", 1'b0, 4'h0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
